dcache_nway: RTL and testbench
==============================

DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity (power of 2, 2..8).
REQ-002 SHALL have parameter INDEX_W, default 9, log2 of set count.
REQ-003 SHALL have parameter LINE_BYTES, default 64, line size (power of 2, 16..128); OFF_W = log2(LINE_BYTES).
REQ-004 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: enable  in  1  request valid, sampled in IDLE only.
REQ-007 SHALL have ports: wen  in  1  store when 1, load when 0.
REQ-008 SHALL have ports: clflush  in  1  flush the line holding addr; overrides wen.
REQ-009 SHALL have ports: addr  in  64  byte address, 8-byte aligned.
REQ-010 SHALL have ports: wdata  in  64, wstrb  in  8; store data and byte enables.
REQ-011 SHALL have ports: rdata  out  64, done  out  1; load data, completion pulse.
REQ-012 SHALL have ports: drequest  out  1, dreqack  in  1, dwrenable  out  1, daddr  out  64.
REQ-013 SHALL have ports: drdata  in  LINE_BYTES*8, dwdata  out  LINE_BYTES*8, ddone  in  1.

Function
REQ-014 SHALL split addr into offset [OFF_W-1:0], index [OFF_W+:INDEX_W], tag (remaining upper bits).
REQ-015 SHALL use FSM states IDLE, LOOKUP, WB, FILL, with transitions defined in REQ-016 to REQ-022.
REQ-016 SHALL, in IDLE with enable=1, latch addr/wdata/wstrb/op and go to LOOKUP next cycle; enable is ignored outside IDLE.
REQ-017 SHALL, in LOOKUP, compare tags in all ways in parallel; a hit is valid plus tag-equal, and at most one way hits.
REQ-018 SHALL, on a load or store hit, return to IDLE and pulse done for exactly one cycle, 2 cycles after accept; a load drives rdata with the hit word; a store merges wdata per wstrb and sets dirty.
REQ-019 SHALL, on a miss, select a victim: the lowest-index invalid way if any, else the tree-PLRU way; go to WB if the victim is dirty, else to FILL.
REQ-020 SHALL, in WB, hold drequest=1 and dwrenable=1 until the cycle dreqack=1, drive dwdata with the victim line and daddr={victim tag, index, OFF_W zeros}, and go to FILL on ddone.
REQ-021 SHALL, in FILL, hold drequest=1 and dwrenable=0 until dreqack, with daddr set to the line-aligned request address; on ddone: install drdata, merge a pending store, set valid, set tag, set dirty=store, pulse done with rdata from the filled line, and return to IDLE.
REQ-022 SHALL handle clflush: hit+dirty -> WB, then invalidate the line and pulse done; hit+clean -> invalidate and pulse done from LOOKUP; miss -> pulse done from LOOKUP.
REQ-023 SHALL update the PLRU tree on every load/store hit and fill, pointing it away from the accessed way; flush SHALL NOT touch PLRU.
REQ-024 SHALL treat dreqack and ddone in the same cycle as both occurring: drop drequest and advance the state.
REQ-025 SHALL hold rdata stable from done until the next done; outputs not in use are 0.
REQ-026 SHALL flag a simulation assertion error when addr[2:0]!=0 is accepted.

Reset
REQ-027 SHALL, on reset_n=0 (any cycle, including mid-WB/FILL): state=IDLE; done, drequest and dwrenable = 0; rdata, daddr and dwdata = 0; all valid, dirty and PLRU bits = 0; data and tag arrays are not reset.
REQ-028 SHALL abandon any in-flight memory transaction on reset without completing it.

Structure
REQ-029 SHALL place the FSM state enum, the tag-entry struct (valid, dirty, tag) and a line-address helper function in shared package dcache_pkg.
REQ-030 SHALL implement tree-PLRU as sub-module plru_tree (parameter WAYS) with touch and victim ports.

Verification (WAYS=4, INDEX_W=6, LINE_BYTES=64; memory model acks after 1 cycle and signals ddone after 3 cycles)
REQ-031 SHALL cover: cold load 0x1000 -> FILL at daddr 0x1000, done with rdata = mem word, no WB.
REQ-032 SHALL cover: store 0x1008 wdata=0xAABB, wstrb=0x03, then load 0x1008 -> hit, done 2 cycles after accept, rdata low 16 bits 0xAABB, remaining bytes unchanged.
REQ-033 SHALL cover: 5 distinct tags to index 0 (addr 0x0, 0x1000, 0x2000, 0x3000, 0x4000) with the first one dirty -> PLRU victim = way 0 written back at daddr 0x0, then fill of 0x4000.
REQ-034 SHALL cover: clflush of a dirty line 0x2000 -> WB at daddr 0x2000 then done; a subsequent load of 0x2000 misses.
REQ-035 SHALL cover: reset_n pulsed low during FILL -> drequest=0 within the same cycle; a reload of that address misses.
REQ-036 SHALL cover: dreqack and ddone in the same cycle, and enable held high while busy -> exactly one done per accepted request.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the n-way data cache: FSM states, request ops, tag entries, line addressing.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_STORE,
        OP_FLUSH
    } op_t;

    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [63:0] tag;
    } tag_entry_t;

    function automatic logic [63:0] line_addr(input logic [63:0] a, input int unsigned off_w);
        return a & ~((64'd1 << off_w) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_plru.sv
// Per-set tree pseudo-LRU: victim is combinational from the set's tree, touch updates it on the next edge.
// Touch flips every node on the accessed way's path so the tree points away from it; no backpressure.
module plru_tree #(
    parameter int WAYS    = 4,
    parameter int INDEX_W = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [INDEX_W-1:0]       idx,
    input  logic                     touch_vld,
    input  logic [$clog2(WAYS)-1:0]  touch_way,
    output logic [$clog2(WAYS)-1:0]  victim
);
    localparam int LVL   = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] tree_q [1 << INDEX_W];
    logic [NODES-1:0] cur;
    logic [NODES-1:0] tree_d;

    // Node n has children 2n+1 (lower ways) and 2n+2; a node bit of 1 steers the victim upward.
    always_comb begin
        int node;
        cur    = tree_q[idx];
        tree_d = cur;
        node   = 0;
        for (int l = 0; l < LVL; l++) begin
            node = 2 * node + 1 + int'(cur[node]);
        end
        victim = LVL'(node - NODES);
        for (int l = 0; l < LVL; l++) begin
            tree_d[(1 << l) - 1 + int'(touch_way >> (LVL - l))] = ~touch_way[LVL - 1 - l];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tree_q <= '{default: '0};
        end else if (touch_vld) begin
            tree_q[idx] <= tree_d;
        end
    end

endmodule

// File: rtl/dcache_nway.sv
// N-way write-back data cache: hits complete 2 cycles after accept, misses wait on the line memory.
// Requests are taken only in IDLE; memory side holds drequest until dreqack, then waits for ddone.
module dcache_nway import dcache_pkg::*; #(
    parameter int WAYS       = 4,
    parameter int INDEX_W    = 9,
    parameter int LINE_BYTES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    wen,
    input  logic                    clflush,
    input  logic [63:0]             addr,
    input  logic [63:0]             wdata,
    input  logic [7:0]              wstrb,
    output logic [63:0]             rdata,
    output logic                    done,
    output logic                    drequest,
    input  logic                    dreqack,
    output logic                    dwrenable,
    output logic [63:0]             daddr,
    input  logic [LINE_BYTES*8-1:0] drdata,
    output logic [LINE_BYTES*8-1:0] dwdata,
    input  logic                    ddone
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int SETS   = 1 << INDEX_W;
    localparam int WW     = $clog2(WAYS);
    localparam int TAG_W  = 64 - OFF_W - INDEX_W;
    localparam int WSEL_W = OFF_W - 3;

    state_t             state_q;
    op_t                op_q;
    logic [63:0]        addr_q, wdata_q, rdata_q, daddr_q;
    logic [7:0]         wstrb_q;
    logic [WW-1:0]      way_q;
    logic               done_q, drequest_q, dwrenable_q;
    logic [LINE_W-1:0]  dwdata_q;
    logic [SETS-1:0]    valid_q [WAYS];
    logic [SETS-1:0]    dirty_q [WAYS];
    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [LINE_W-1:0]  data_q  [WAYS][SETS];

    logic [INDEX_W-1:0] idx;
    logic [63:0]        req_tag, victim_addr;
    logic [WSEL_W-1:0]  wsel;
    tag_entry_t         ent [WAYS];
    tag_entry_t         sel_ent;
    logic               hit, inv_found, fill_done, touch_vld, arr_we;
    logic [WW-1:0]      hit_way, inv_way, plru_victim, sel_way;
    logic [LINE_W-1:0]  sel_line, line_d;
    logic [63:0]        word_d;

    assign idx     = addr_q[OFF_W +: INDEX_W];
    assign req_tag = addr_q >> (OFF_W + INDEX_W);
    assign wsel    = addr_q[OFF_W-1:3];

    // Scanning downward leaves the lowest-index invalid way in inv_way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            ent[w] = '{valid: valid_q[w][idx], dirty: dirty_q[w][idx], tag: 64'(tag_q[w][idx])};
            if (ent[w].valid && ent[w].tag == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!ent[w].valid) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
    end

    always_comb begin
        sel_way     = (state_q == LOOKUP) ? (hit ? hit_way : (inv_found ? inv_way : plru_victim)) : way_q;
        sel_ent     = ent[sel_way];
        sel_line    = data_q[sel_way][idx];
        victim_addr = (sel_ent.tag << (OFF_W + INDEX_W)) | (64'(idx) << OFF_W);
        line_d      = (state_q == FILL) ? drdata : sel_line;
        if (op_q == OP_STORE) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb_q[b]) line_d[{wsel, 3'(b), 3'b000} +: 8] = wdata_q[b*8 +: 8];
            end
        end
        word_d    = line_d[{wsel, 6'b000000} +: 64];
        fill_done = (state_q == FILL) && ddone;
        arr_we    = ((state_q == LOOKUP) && hit && (op_q == OP_STORE)) || fill_done;
        touch_vld = ((state_q == LOOKUP) && hit && (op_q != OP_FLUSH)) || fill_done;
    end

    plru_tree #(.WAYS(WAYS), .INDEX_W(INDEX_W)) u_plru (
        .clk       (clk),
        .reset_n   (reset_n),
        .idx       (idx),
        .touch_vld (touch_vld),
        .touch_way (sel_way),
        .victim    (plru_victim)
    );

    always_ff @(posedge clk) begin
        if (arr_we)    data_q[sel_way][idx] <= line_d;
        if (fill_done) tag_q[sel_way][idx]  <= req_tag[TAG_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= OP_LOAD;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            way_q       <= '0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            drequest_q  <= 1'b0;
            dwrenable_q <= 1'b0;
            daddr_q     <= '0;
            dwdata_q    <= '0;
            valid_q     <= '{default: '0};
            dirty_q     <= '{default: '0};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (enable) begin
                    assert (addr[2:0] == 3'b000);
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                    op_q    <= clflush ? OP_FLUSH : (wen ? OP_STORE : OP_LOAD);
                    state_q <= LOOKUP;
                end
                LOOKUP: begin
                    way_q <= sel_way;
                    if ((op_q == OP_FLUSH && hit && sel_ent.dirty) ||
                        (op_q != OP_FLUSH && !hit && sel_ent.valid && sel_ent.dirty)) begin
                        state_q     <= WB;
                        drequest_q  <= 1'b1;
                        dwrenable_q <= 1'b1;
                        daddr_q     <= victim_addr;
                        dwdata_q    <= sel_line;
                    end else if (op_q == OP_FLUSH || hit) begin
                        if (op_q == OP_FLUSH && hit) valid_q[hit_way][idx] <= 1'b0;
                        if (op_q == OP_STORE)        dirty_q[hit_way][idx] <= 1'b1;
                        if (op_q == OP_LOAD)         rdata_q <= word_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q     <= FILL;
                        drequest_q  <= 1'b1;
                        dwrenable_q <= 1'b0;
                        daddr_q     <= line_addr(addr_q, OFF_W);
                    end
                end
                WB: begin
                    if (dreqack || ddone) begin
                        drequest_q  <= 1'b0;
                        dwrenable_q <= 1'b0;
                    end
                    if (ddone) begin
                        dwdata_q <= '0;
                        if (op_q == OP_FLUSH) begin
                            valid_q[way_q][idx] <= 1'b0;
                            dirty_q[way_q][idx] <= 1'b0;
                            daddr_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            drequest_q <= 1'b1;
                            daddr_q    <= line_addr(addr_q, OFF_W);
                            state_q    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (dreqack || ddone) drequest_q <= 1'b0;
                    if (ddone) begin
                        valid_q[way_q][idx] <= 1'b1;
                        dirty_q[way_q][idx] <= (op_q == OP_STORE);
                        rdata_q <= word_d;
                        daddr_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign drequest  = drequest_q;
    assign dwrenable = dwrenable_q;
    assign daddr     = daddr_q;
    assign dwdata    = dwdata_q;

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway with a one-request line memory driven from the stimulus sequence.
module tb_dcache_nway;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          reset_n, enable, wen, clflush, dreqack, ddone;
    logic [63:0]   addr, wdata;
    logic [7:0]    wstrb;
    logic [LW-1:0] drdata;
    logic [63:0]   rdata, daddr;
    logic          done, drequest, dwrenable;
    logic [LW-1:0] dwdata;

    int            vecs = 0;
    int            errs = 0;
    int            n_done, n_wb, n_fill, t_done_k;
    logic [63:0]   wb_addr, fill_addr, rd;
    logic [LW-1:0] wb_data;
    logic          proto_ok, same_mode, hold_en, seen;

    dcache_nway #(.WAYS(4), .INDEX_W(6), .LINE_BYTES(64)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .wen(wen), .clflush(clflush),
        .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .done(done),
        .drequest(drequest), .dreqack(dreqack), .dwrenable(dwrenable), .daddr(daddr),
        .drdata(drdata), .dwdata(dwdata), .ddone(ddone)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memw(input logic [63:0] a);
        return {a[31:0], ~a[31:0]};
    endfunction

    function automatic logic [LW-1:0] mline(input logic [63:0] la);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = memw(la + 64'(i * 8));
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request plus memory service; records what the memory saw and when done came.
    task automatic xact(input int op, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int            cnt;
        logic [63:0]   cur;
        @(negedge clk);
        enable = 1'b1; wen = (op == 1); clflush = (op == 2); addr = a; wdata = d; wstrb = s;
        n_done = 0; n_wb = 0; n_fill = 0; t_done_k = 0; proto_ok = 1'b1;
        wb_addr = '1; fill_addr = '1; wb_data = '1; cnt = 0; cur = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            dreqack = 1'b0; ddone = 1'b0;
            if (!hold_en || done) enable = 1'b0;
            if (done) begin
                n_done++;
                if (t_done_k == 0) begin t_done_k = k; rd = rdata; end
            end
            if (cnt == 0) begin
                if (drequest) begin
                    cnt = 1; cur = daddr;
                    if (dwrenable) begin n_wb++; wb_addr = daddr; wb_data = dwdata; end
                    else begin n_fill++; fill_addr = daddr; end
                end
            end else begin
                cnt++;
                if (cnt == 2) begin
                    if (!drequest) proto_ok = 1'b0;
                    dreqack = 1'b1;
                    if (same_mode) begin ddone = 1'b1; drdata = mline(cur); cnt = 0; end
                end else if (cnt == 3) begin
                    if (drequest) proto_ok = 1'b0;
                end else if (cnt == 4) begin
                    ddone = 1'b1; drdata = mline(cur); cnt = 0;
                end
            end
            if (t_done_k != 0 && k >= t_done_k + 4) break;
        end
        enable = 1'b0;
        if (n_done > 0) chk("rdata_hold", rdata, rd);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0; enable = 1'b0; dreqack = 1'b0; ddone = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1; enable = 1'b0; wen = 1'b0; clflush = 1'b0; addr = '0; wdata = '0;
        wstrb = '0; dreqack = 1'b0; ddone = 1'b0; drdata = '0; same_mode = 1'b0; hold_en = 1'b0;
        rd = '0;
        #2 reset_n = 1'b0;
        #2;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_drequest", 64'(drequest), 64'd0);
        chk("rst_dwrenable", 64'(dwrenable), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_daddr", daddr, 64'd0);
        chk("rst_dwdata", 64'(|dwdata), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Cold load, then store hit and load hit of the same line
        xact(0, 64'h1000, 64'h0, 8'h00);
        chk("a_fill_cnt", 64'(n_fill), 64'd1);
        chk("a_fill_addr", fill_addr, 64'h1000);
        chk("a_wb_cnt", 64'(n_wb), 64'd0);
        chk("a_done_cnt", 64'(n_done), 64'd1);
        chk("a_rdata", rd, memw(64'h1000));
        chk("a_proto", 64'(proto_ok), 64'd1);
        xact(1, 64'h1008, 64'hAABB, 8'h03);
        chk("a_st_lat", 64'(t_done_k), 64'd2);
        chk("a_st_fill", 64'(n_fill), 64'd0);
        xact(0, 64'h1008, 64'h0, 8'h00);
        chk("a_ld_lat", 64'(t_done_k), 64'd2);
        chk("a_ld_rdata", rd, (memw(64'h1008) & ~64'hFFFF) | 64'hAABB);
        pulse_reset();

        // Five tags into set 0, first one dirty
        xact(1, 64'h0, 64'h1122334455667788, 8'hFF);
        chk("b_st_fill_addr", fill_addr, 64'h0);
        xact(0, 64'h1000, 64'h0, 8'h00);
        xact(0, 64'h2000, 64'h0, 8'h00);
        xact(0, 64'h3000, 64'h0, 8'h00);
        chk("b_w3_wb", 64'(n_wb), 64'd0);
        chk("b_w3_rdata", rd, memw(64'h3000));
        xact(0, 64'h4000, 64'h0, 8'h00);
        chk("b_wb_cnt", 64'(n_wb), 64'd1);
        chk("b_wb_addr", wb_addr, 64'h0);
        chk("b_wb_word0", wb_data[63:0], 64'h1122334455667788);
        chk("b_wb_word1", wb_data[127:64], memw(64'h8));
        chk("b_fill_addr", fill_addr, 64'h4000);
        chk("b_rdata", rd, memw(64'h4000));
        chk("b_done_cnt", 64'(n_done), 64'd1);
        chk("b_proto", 64'(proto_ok), 64'd1);

        // Flush of dirty, clean and absent lines
        xact(1, 64'h2000, 64'hCAFE, 8'h0F);
        chk("c_st_lat", 64'(t_done_k), 64'd2);
        xact(2, 64'h2000, 64'h0, 8'h00);
        chk("c_fl_wb_cnt", 64'(n_wb), 64'd1);
        chk("c_fl_wb_addr", wb_addr, 64'h2000);
        chk("c_fl_wb_word0", wb_data[63:0], 64'h00002000_0000CAFE);
        chk("c_fl_fill", 64'(n_fill), 64'd0);
        chk("c_fl_done", 64'(n_done), 64'd1);
        xact(0, 64'h2000, 64'h0, 8'h00);
        chk("c_reload_fill", 64'(n_fill), 64'd1);
        chk("c_reload_rdata", rd, memw(64'h2000));
        xact(2, 64'h2000, 64'h0, 8'h00);
        chk("c_clean_lat", 64'(t_done_k), 64'd2);
        chk("c_clean_wb", 64'(n_wb), 64'd0);
        xact(2, 64'h2000, 64'h0, 8'h00);
        chk("c_miss_lat", 64'(t_done_k), 64'd2);

        // Reset in the middle of a fill
        @(negedge clk);
        enable = 1'b1; wen = 1'b0; clflush = 1'b0; addr = 64'h5000;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            enable = 1'b0;
            if (drequest) seen = 1'b1;
        end
        chk("d_fill_started", 64'(seen), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("d_rst_drequest", 64'(drequest), 64'd0);
        chk("d_rst_daddr", daddr, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        xact(0, 64'h5000, 64'h0, 8'h00);
        chk("d_reload_fill", 64'(n_fill), 64'd1);
        chk("d_reload_addr", fill_addr, 64'h5000);

        // Ack and ddone together, enable held high while busy
        same_mode = 1'b1; hold_en = 1'b1;
        xact(0, 64'h1000, 64'h0, 8'h00);
        chk("e_ld_done_cnt", 64'(n_done), 64'd1);
        chk("e_ld_rdata", rd, memw(64'h1000));
        xact(1, 64'h1008, 64'hAABB, 8'h03);
        chk("e_st_done_cnt", 64'(n_done), 64'd1);
        xact(1, 64'h5008, 64'h77, 8'h01);
        xact(0, 64'h2000, 64'h0, 8'h00);
        xact(0, 64'h3000, 64'h0, 8'h00);
        xact(0, 64'h6000, 64'h0, 8'h00);
        chk("e_wb_cnt", 64'(n_wb), 64'd1);
        chk("e_wb_addr", wb_addr, 64'h1000);
        chk("e_wb_word1", wb_data[127:64], (memw(64'h1008) & ~64'hFFFF) | 64'hAABB);
        chk("e_fill_addr", fill_addr, 64'h6000);
        chk("e_done_cnt", 64'(n_done), 64'd1);
        chk("e_rdata", rd, memw(64'h6000));
        chk("e_proto", 64'(proto_ok), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
